// File: rtl/uart_tx_param_pkg.sv
// Shared encodings for the UART TX path: parity modes and framer FSM states.
// Pure constants and helpers; no latency or backpressure of its own.
// Shared by the TX framer today and the RX path later.
package uart_tx_param_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   // 2'b11 is a second encoding of "no parity"
   function automatic logic par_enabled(input logic [1:0] mode);
      case (mode)
         PAR_ODD, PAR_EVEN: return 1'b1;
         PAR_NONE:          return 1'b0;
         default:           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO, power-of-two depth, head word visible on rd_data while non-empty.
// Latency: a pushed word is readable the cycle after the push.
// Backpressure: push while full and pop while empty are ignored; push and pop together both occur.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: FIFO-fed framer with parity and stop count latched per frame.
// Latency: a word popped in an IDLE cycle drives the start bit from the next cycle.
// Backpressure: in_ready = FIFO not full; one IDLE cycle separates back-to-back frames.
module uart_tx_param #(
   parameter int CLOCK_DIV  = 104,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [DATA_BITS-1:0]          in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [1:0]                    parity_mode,
   input  logic                          two_stop,
   output logic                          tx,
   output logic                          busy,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   import uart_tx_param_pkg::*;

   localparam logic [15:0] DIV_M1   = 16'(CLOCK_DIV - 1);
   localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

   logic [2:0]           state;
   logic [15:0]          baud_cnt;
   logic [3:0]           bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 par_en;
   logic                 par_bit;
   logic                 stop2;
   logic                 bit_end;
   logic                 last_stop;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] head;

   uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (in_valid),
      .wr_data (in_data),
      .pop     (fifo_pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign bit_end   = (baud_cnt == DIV_M1);
   assign last_stop = (bit_idx == {3'b000, stop2});
   assign fifo_pop  = (state == IDLE) && !fifo_empty;
   assign in_ready  = !fifo_full;
   assign busy      = (state != IDLE) || !fifo_empty;
   assign tx_done   = (state == STOP) && bit_end && last_stop;

   // tx is registered and loaded with the level of the state being entered
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         par_en   <= 1'b0;
         par_bit  <= 1'b0;
         stop2    <= 1'b0;
         tx       <= 1'b1;
      end else begin
         if (state != IDLE) baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
         case (state)
            IDLE: begin
               if (fifo_pop) begin
                  shift    <= head;
                  par_en   <= par_enabled(parity_mode);
                  par_bit  <= (parity_mode == PAR_EVEN) ? ^head : ~^head;
                  stop2    <= two_stop;
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  tx    <= shift[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  shift <= shift >> 1;
                  if (bit_idx == LAST_BIT) begin
                     bit_idx <= '0;
                     tx      <= par_en ? par_bit : 1'b1;
                     state   <= par_en ? PARITY : STOP;
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                     tx      <= shift[1];
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  bit_idx <= '0;
                  tx      <= 1'b1;
                  state   <= STOP;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (last_stop) begin
                     bit_idx <= '0;
                     state   <= IDLE;
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                  end
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: per-cycle waveform model plus literal frame checks.
module tb_uart_tx_param;
   localparam int C     = 4;
   localparam int DB    = 8;
   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [1:0] parity_mode = 2'b00;
   logic       two_stop = 1'b0;
   logic       tx, busy, tx_done;
   logic [2:0] fifo_level;

   logic [4:0] d5_in_data = '0;
   logic       d5_in_valid = 1'b0;
   logic       d5_in_ready, d5_tx, d5_busy, d5_done;
   logic [2:0] d5_level;

   logic sel5 = 1'b0;
   logic m_tx, m_done;
   assign m_tx   = sel5 ? d5_tx : tx;
   assign m_done = sel5 ? d5_done : tx_done;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   uart_tx_param #(.CLOCK_DIV(C), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .parity_mode(parity_mode), .two_stop(two_stop),
      .tx(tx), .busy(busy), .tx_done(tx_done), .fifo_level(fifo_level)
   );

   uart_tx_param #(.CLOCK_DIV(C), .DATA_BITS(5), .FIFO_DEPTH(DEPTH)) dut5 (
      .clock(clock), .reset_n(reset_n), .in_data(d5_in_data), .in_valid(d5_in_valid),
      .in_ready(d5_in_ready), .parity_mode(2'b00), .two_stop(1'b0),
      .tx(d5_tx), .busy(d5_busy), .tx_done(d5_done), .fifo_level(d5_level)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Model: queued words plus the expected line level / done flag for every future cycle
   logic [7:0] mq[$];
   bit         wave_tx[$];
   bit         wave_done[$];
   bit         m_acc;

   task automatic add_bit(input bit v, input int cycles, input bit ends_frame);
      for (int k = 0; k < cycles; k++) begin
         wave_tx.push_back(v);
         wave_done.push_back(ends_frame && (k == cycles - 1));
      end
   endtask

   task automatic model_frame(input logic [7:0] d, input logic [1:0] m, input logic ts);
      add_bit(1'b0, C, 1'b0);
      for (int b = 0; b < DB; b++) add_bit(d[b], C, 1'b0);
      if (m == 2'b01) add_bit(~^d, C, 1'b0);
      if (m == 2'b10) add_bit(^d, C, 1'b0);
      add_bit(1'b1, ts ? 2 * C : C, 1'b1);
   endtask

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         wave_tx.delete();
         wave_done.delete();
      end else begin
         m_acc = in_valid && (mq.size() < DEPTH);
         if (wave_tx.size() != 0) begin
            void'(wave_tx.pop_front());
            void'(wave_done.pop_front());
         end else if (mq.size() != 0) begin
            model_frame(mq.pop_front(), parity_mode, two_stop);
         end
         if (m_acc) mq.push_back(in_data);
      end
   end

   always @(negedge clock) begin
      if (reset_n) begin
         chk("tx", tx, (wave_tx.size() != 0) ? wave_tx[0] : 1'b1);
         chk("tx_done", tx_done, (wave_done.size() != 0) ? wave_done[0] : 1'b0);
         chk("busy", busy, (wave_tx.size() != 0) || (mq.size() != 0));
         chk("fifo_level", fifo_level, mq.size());
         chk("in_ready", in_ready, mq.size() < DEPTH);
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push_word(input logic [7:0] d, output int stalls);
      stalls   = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && stalls < 2000) begin
         @(negedge clock);
         stalls++;
      end
      if (stalls >= 2000) chk("push_timeout", stalls, 0);
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   // Waits for a start bit, samples each bit mid-period, returns cycles up to and including tx_done.
   task automatic measure(output logic [15:0] bits, output int len);
      int n = 0;
      int idx;
      bits = '0;
      while (m_tx !== 1'b0 && n < 3000) begin
         @(negedge clock);
         n++;
      end
      chk("start_seen", n < 3000, 1);
      for (len = 1; len < 100; len++) begin
         idx = (len - 1) / C;
         if ((len - 1) % C == 1 && idx < 16) bits[idx] = m_tx;
         if (m_done === 1'b1) break;
         @(negedge clock);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 5000) begin
         @(negedge clock);
         n++;
      end
      chk("drain", n < 5000, 1);
   endtask

   initial begin
      logic [15:0] bits;
      int          len;
      int          stall;
      int          lows;
      logic [7:0]  words [6];
      int          exp_lvl [5];
      logic [7:0]  par_d [3];
      logic [1:0]  par_m [3];
      logic        par_p [3];

      exp_lvl = '{1, 2, 3, 4, 4};
      par_d = '{8'h03, 8'h07, 8'h07};
      par_m = '{2'b10, 2'b10, 2'b01};
      par_p = '{1'b0, 1'b1, 1'b0};

      #1 reset_n = 1'b0;
      #2;
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_level", fifo_level, 0);
      @(posedge clock);
      #2 reset_n = 1'b1;
      @(negedge clock);

      push_word(8'hA5, stall);
      measure(bits, len);
      chk("a5_bits", bits[9:0], 10'h34A);
      chk("a5_len", len, 40);
      @(negedge clock);
      chk("a5_busy_after", busy, 0);

      for (int i = 0; i < 3; i++) begin
         parity_mode = par_m[i];
         push_word(par_d[i], stall);
         measure(bits, len);
         chk("par_len", len, 44);
         chk("par_data", bits[8:1], par_d[i]);
         chk("par_bit", bits[9], par_p[i]);
         chk("par_stop", bits[10], 1);
      end
      parity_mode = 2'b00;

      two_stop = 1'b1;
      fork
         begin
            push_word(8'hFF, stall);
            push_word(8'h33, stall);
            repeat (10) @(negedge clock);
            two_stop = 1'b0;
         end
         begin
            measure(bits, len);
            chk("ts_len1", len, 44);
            chk("ts_data1", bits[8:1], 8'hFF);
            measure(bits, len);
            chk("ts_len2", len, 40);
            chk("ts_data2", bits[8:1], 8'h33);
         end
      join
      wait_idle();

      for (int i = 0; i < 6; i++) words[i] = 8'($urandom_range(0, 255));
      fork
         begin
            push_word(words[0], stall);
            for (int i = 1; i < 6; i++) begin
               push_word(words[i], stall);
               chk("burst_level", fifo_level, exp_lvl[i-1]);
               if (i == 4) chk("burst_full_ready", in_ready, 0);
               if (i == 5) chk("burst_stalled", stall > 0, 1);
            end
         end
         begin
            for (int i = 0; i < 6; i++) begin
               measure(bits, len);
               chk("burst_len", len, 40);
               chk("burst_data", bits[8:1], words[i]);
            end
         end
      join
      wait_idle();

      for (int i = 0; i < 24; i++) begin
         repeat ($urandom_range(0, 30)) @(negedge clock);
         if ($urandom_range(0, 2) == 0) begin
            parity_mode = 2'($urandom_range(0, 3));
            two_stop    = 1'($urandom_range(0, 1));
         end
         push_word(8'($urandom_range(0, 255)), stall);
      end
      wait_idle();
      parity_mode = 2'b00;
      two_stop    = 1'b0;

      push_word(8'h5A, stall);
      push_word(8'hC3, stall);
      push_word(8'h0F, stall);
      chk("rst_pre_level", fifo_level, 2);
      repeat (4) @(negedge clock);
      chk("rst_pre_tx", tx, 0);
      @(posedge clock);
      #1 reset_n = 1'b0;
      #1;
      chk("midrst_tx", tx, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_level", fifo_level, 0);
      chk("midrst_ready", in_ready, 1);
      @(posedge clock);
      #2 reset_n = 1'b1;
      lows = 0;
      repeat (100) begin
         @(negedge clock);
         if (tx !== 1'b1) lows++;
      end
      chk("no_stale_frame", lows, 0);
      chk("post_rst_busy", busy, 0);

      sel5 = 1'b1;
      chk("d5_ready", d5_in_ready, 1);
      d5_in_data  = 5'h1F;
      d5_in_valid = 1'b1;
      @(negedge clock);
      d5_in_valid = 1'b0;
      chk("d5_level", d5_level, 1);
      measure(bits, len);
      chk("d5_len", len, 28);
      chk("d5_bits", bits[6:0], 7'h7E);
      @(negedge clock);
      chk("d5_busy_after", d5_busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
